// File: rtl/addsub_pipe.sv
// Two-stage pipelined add/sub/compare/arith-shift unit for MIPS funct codes.
// S1 holds the decoded class and conditioned operands; S2 holds the result and flags.
module addsub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SAW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SAW-1:0]   sa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam logic [5:0] OpAdd  = 6'b100000;
  localparam logic [5:0] OpAddu = 6'b100001;
  localparam logic [5:0] OpSub  = 6'b100010;
  localparam logic [5:0] OpSubu = 6'b100011;
  localparam logic [5:0] OpSlt  = 6'b101010;
  localparam logic [5:0] OpSltu = 6'b101011;
  localparam logic [5:0] OpSra  = 6'b000011;
  localparam logic [5:0] OpSrav = 6'b000111;

  typedef enum logic [2:0] {ClsArith, ClsSlt, ClsSltu, ClsSra, ClsIll} op_cls_e;

  // Decode
  op_cls_e          cls_d;
  logic             inv_d;
  logic             chk_d;
  logic [SAW-1:0]   sh_d;

  always_comb begin
    cls_d = ClsIll;
    inv_d = 1'b0;
    chk_d = 1'b0;
    sh_d  = sa;
    case (op)
      OpAdd:   begin cls_d = ClsArith; chk_d = 1'b1; end
      OpAddu:  cls_d = ClsArith;
      OpSub:   begin cls_d = ClsArith; inv_d = 1'b1; chk_d = 1'b1; end
      OpSubu:  begin cls_d = ClsArith; inv_d = 1'b1; end
      OpSlt:   begin cls_d = ClsSlt;   inv_d = 1'b1; end
      OpSltu:  begin cls_d = ClsSltu;  inv_d = 1'b1; end
      OpSra:   cls_d = ClsSra;
      OpSrav:  begin cls_d = ClsSra;   sh_d = a[SAW-1:0]; end
      default: cls_d = ClsIll;
    endcase
  end

  // Stage registers
  logic             s1_valid_q;
  op_cls_e          s1_cls_q;
  logic             s1_chk_q;
  logic             s1_cin_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [SAW-1:0]   s1_sh_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] r_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
  logic             ill_q;
  logic             sticky_q;

  logic s1_move;

  assign s1_move  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_move;

  // Execute (between S1 and S2)
  logic [WIDTH:0]   sum;
  logic             ovf_raw;
  logic [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             ill_d;

  assign sum = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_cin_q};
  // Same-sign operands yielding an opposite-sign sum; with b pre-inverted this also covers a-b.
  assign ovf_raw = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
  assign sra_res = $signed(s1_b_q) >>> s1_sh_q;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    ill_d = 1'b0;
    case (s1_cls_q)
      ClsArith: begin
        res_d = sum[WIDTH-1:0];
        ovf_d = s1_chk_q && ovf_raw;
      end
      // Sign of the true difference: wrapped sign corrected by overflow.
      ClsSlt:  res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
      ClsSltu: res_d = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
      ClsSra:  res_d = sra_res;
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= ClsIll;
      s1_chk_q   <= 1'b0;
      s1_cin_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sh_q    <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_cls_q <= cls_d;
        s1_chk_q <= chk_d;
        s1_cin_q <= inv_d;
        s1_a_q   <= a;
        s1_b_q   <= inv_d ? ~b : b;
        s1_sh_q  <= sh_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      r_q        <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
    end else if (s1_move) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        r_q    <= res_d;
        zero_q <= (res_d == '0);
        neg_q  <= res_d[WIDTH-1];
        ovf_q  <= ovf_d;
        ill_q  <= ill_d;
      end
    end
  end

  // Set on a consumed overflowing result; set beats a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else if (s2_valid_q && out_ready && ovf_q) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign out_valid  = s2_valid_q;
  assign r          = r_q;
  assign zero       = zero_q;
  assign negative   = neg_q;
  assign overflow   = ovf_q;
  assign illegal    = ill_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed vector table, stall/reset sequences,
// randomized traffic against an arithmetic scoreboard, and a 16-bit build.
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, clr_sticky;
  logic [5:0]  op;
  logic [31:0] a, b, r;
  logic [4:0]  sa;
  logic        zero, negative, overflow, illegal, ovf_sticky;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [5:0]  h_op;
  logic [15:0] h_a, h_b, h_r;
  logic [3:0]  h_sa;
  logic        h_zero, h_negative, h_overflow, h_illegal, h_ovf_sticky;

  always #5 clk = ~clk;

  addsub_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a),
    .b(b), .sa(sa), .out_valid(out_valid), .out_ready(out_ready), .r(r), .zero(zero),
    .negative(negative), .overflow(overflow), .illegal(illegal), .ovf_sticky(ovf_sticky),
    .clr_sticky(clr_sticky)
  );

  addsub_pipe #(.WIDTH(16), .SAW(4)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
    .a(h_a), .b(h_b), .sa(h_sa), .out_valid(h_out_valid), .out_ready(h_out_ready), .r(h_r),
    .zero(h_zero), .negative(h_negative), .overflow(h_overflow), .illegal(h_illegal),
    .ovf_sticky(h_ovf_sticky), .clr_sticky(1'b0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference model: plain integer arithmetic on the funct code.
  typedef struct packed {
    logic [31:0] r;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        ill;
  } res_t;

  function automatic res_t model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] s);
    res_t o;
    longint sx, sy, t;
    logic signed [31:0] ys;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ys = y;
    o = '0;
    case (f)
      6'h20: begin t = sx + sy; o.r = x + y; o.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      6'h21: o.r = x + y;
      6'h22: begin t = sx - sy; o.r = x - y; o.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      6'h23: o.r = x - y;
      6'h2a: o.r = (sx < sy) ? 32'd1 : 32'd0;
      6'h2b: o.r = (x < y) ? 32'd1 : 32'd0;
      6'h03: o.r = ys >>> s;
      6'h07: o.r = ys >>> x[4:0];
      default: o.ill = 1'b1;
    endcase
    o.zero = (o.r == 32'd0);
    o.neg  = o.r[31];
    return o;
  endfunction

  // Scoreboard: transfers seen at negedge take effect on the following rising edge.
  res_t q[$];
  logic exp_sticky = 1'b0;
  int   n_popped   = 0;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_sticky = 1'b0;
    end else begin
      check("ovf_sticky", {63'd0, ovf_sticky}, {63'd0, exp_sticky});
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected out_valid", 64'd1, 64'd0);
        end else begin
          check("result", {27'd0, r, zero, negative, overflow, illegal}, {27'd0, q[0]});
          if (out_ready) begin
            if (q[0].ovf) exp_sticky = 1'b1;
            else if (clr_sticky) exp_sticky = 1'b0;
            void'(q.pop_front());
            n_popped++;
          end else if (clr_sticky) begin
            exp_sticky = 1'b0;
          end
        end
      end else if (clr_sticky) begin
        exp_sticky = 1'b0;
      end
      if (in_valid && in_ready) q.push_back(model(op, a, b, sa));
    end
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] r;
    logic        ovf;
    logic        ill;
  } vec_t;

  vec_t vecs[12];

  // Present at one edge+1, accepted at the next edge, result visible after the one after.
  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    op = v.op; a = v.a; b = v.b; sa = v.sa; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " early out_valid"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, " r/zero/neg/ovf/ill"}, {28'd0, r, zero, negative, overflow, illegal},
          {28'd0, v.r, v.r == 32'd0, v.r[31], v.ovf, v.ill});
    @(posedge clk); #1;
  endtask

  task automatic h_run(input logic [5:0] f, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] s, input logic [15:0] er, input logic eo, input string tag);
    @(posedge clk); #1;
    h_op = f; h_a = x; h_b = y; h_sa = s; h_in_valid = 1'b1; h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, " w16 valid/r/ovf"}, {46'd0, h_out_valid, h_r, h_overflow}, {46'd0, 1'b1, er, eo});
  endtask

  localparam logic [5:0] OPS[9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2a, 6'h2b, 6'h03, 6'h07, 6'h3f};

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7fffffff;
      1: return 32'h80000000;
      2: return 32'hffffffff;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   dropped;
    int   sent, base, cyc;
    logic fire;

    vecs[0]  = '{6'h20, 32'h7fffffff, 32'h00000001, 5'd0, 32'h80000000, 1'b1, 1'b0};
    vecs[1]  = '{6'h2a, 32'h80000000, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0};
    vecs[2]  = '{6'h2b, 32'h80000000, 32'h00000001, 5'd0, 32'h00000000, 1'b0, 1'b0};
    vecs[3]  = '{6'h23, 32'h00000000, 32'h00000001, 5'd0, 32'hffffffff, 1'b0, 1'b0};
    vecs[4]  = '{6'h03, 32'h00000000, 32'hf0000000, 5'd4, 32'hff000000, 1'b0, 1'b0};
    vecs[5]  = '{6'h07, 32'h00000024, 32'h80000000, 5'd0, 32'hf8000000, 1'b0, 1'b0};
    vecs[6]  = '{6'h3f, 32'h12345678, 32'h9abcdef0, 5'd3, 32'h00000000, 1'b0, 1'b1};
    vecs[7]  = '{6'h22, 32'h80000000, 32'h00000001, 5'd0, 32'h7fffffff, 1'b1, 1'b0};
    vecs[8]  = '{6'h2a, 32'h7fffffff, 32'h80000000, 5'd0, 32'h00000000, 1'b0, 1'b0};
    vecs[9]  = '{6'h21, 32'hffffffff, 32'h00000001, 5'd0, 32'h00000000, 1'b0, 1'b0};
    vecs[10] = '{6'h2b, 32'h00000001, 32'hffffffff, 5'd0, 32'h00000001, 1'b0, 1'b0};
    vecs[11] = '{6'h2a, 32'hffffffff, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    op = '0; a = '0; b = '0; sa = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_op = '0; h_a = '0; h_b = '0; h_sa = '0;
    #12;
    check("reset outputs", {56'd0, out_valid, zero, negative, overflow, illegal, ovf_sticky,
          r == 32'd0, 1'b0}, {56'd0, 8'b0000_0010});
    reset = 1'b0;
    #1;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);

    // Directed table
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("sticky after ovf", {63'd0, ovf_sticky}, 64'd1);

    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky cleared", {63'd0, ovf_sticky}, 64'd0);

    clr_sticky = 1'b1;
    run_vec(vecs[0], "clr+ovf");
    check("sticky set wins", {63'd0, ovf_sticky}, 64'd1);
    clr_sticky = 1'b0;

    // 8 back-to-back ADDs, consumer stalls for 3 cycles mid-stream
    sent = 0; base = n_popped; dropped = 1'b0;
    for (cyc = 0; cyc < 40 && (n_popped - base) < 8; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 8);
      op = 6'h21; a = 32'h100 * sent; b = sent + 1; sa = '0;
      #3;
      fire = in_valid && in_ready;
      if (in_valid && !in_ready) dropped = 1'b1;
      if (fire) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream in_ready dropped", {63'd0, dropped}, 64'd1);
    check("stream delivered", 64'(n_popped - base), 64'd8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
      op = OPS[$urandom_range(0, 8)];
      a  = rnd_operand();
      b  = rnd_operand();
      sa = 5'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("random drained", 64'(q.size()), 64'd0);

    // Fill both stages, then reset asynchronously mid-cycle
    run_vec(vecs[0], "pre-reset");
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = 6'h20; a = 32'h7fffffff; b = 32'd5;
    @(posedge clk); #1;
    a = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full before reset", {62'd0, out_valid, in_ready}, 64'b10);
    #2;
    reset = 1'b1;
    #1;
    check("async reset outputs", {56'd0, out_valid, zero, negative, overflow, illegal,
          ovf_sticky, r == 32'd0, 1'b0}, {56'd0, 8'b0000_0010});
    #4;
    reset = 1'b0; out_ready = 1'b1;
    #1;
    check("post-reset in_ready", {63'd0, in_ready}, 64'd1);
    run_vec(vecs[4], "post-reset");

    // 16-bit build
    h_run(6'h20, 16'h7fff, 16'h0001, 4'd0, 16'h8000, 1'b1, "add");
    h_run(6'h03, 16'h0000, 16'h8000, 4'd15, 16'hffff, 1'b0, "sra");
    h_run(6'h2a, 16'h8000, 16'h0001, 4'd0, 16'h0001, 1'b0, "slt");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
